// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg
// Op-code and state encodings shared by the multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// Radix-2 iterative MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] EntradaA,
  input  logic [WIDTH-1:0] EntradaB,
  input  logic [1:0]       OP,
  input  logic             Start,
  input  logic             WriteHI,
  input  logic             WriteLO,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int c_CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_start;
  logic               w_last;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  // Signed ops have OP[0] == 0; magnitudes feed an unsigned datapath.
  assign w_a_neg = ~OP[0] & EntradaA[WIDTH-1];
  assign w_b_neg = ~OP[0] & EntradaB[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~EntradaA + 1'b1) : EntradaA;
  assign w_b_mag = w_b_neg ? (~EntradaB + 1'b1) : EntradaB;

  assign w_start = (r_state == ST_IDLE) && Start;
  assign w_last  = (r_cnt == c_CNT_W'(WIDTH - 1));

  // Multiply step: multiplier sits in the low half and shifts out LSB-first.
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_mul_next = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide step: remainder in the high half, dividend bits shift in from the
  // low half while quotient bits shift in at the bottom.
  logic [WIDTH:0]     w_part;
  logic               w_fits;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_part     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_fits     = (w_part >= {1'b0, r_mcand});
  // When the divisor fits, the true difference is below 2^WIDTH, so a
  // WIDTH-bit subtract is exact.
  assign w_diff     = w_part[WIDTH-1:0] - r_mcand;
  assign w_rem_next = w_fits ? w_diff : w_part[WIDTH-1:0];
  assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_fits};

  logic [2*WIDTH-1:0] w_acc_next;
  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  // Sign correction of the final step's result.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
  assign w_quo  = r_neg_q ? (~w_acc_next[WIDTH-1:0] + 1'b1)
                          : w_acc_next[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                          : w_acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_mcand == '0) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (Start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      ST_RUN:  Busy = 1'b1;
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_a_raw  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_acc    <= {{WIDTH{1'b0}}, (OP[1] ? w_a_mag : w_b_mag)};
      r_mcand  <= OP[1] ? w_b_mag : w_a_mag;
      r_a_raw  <= EntradaA;
      r_is_div <= OP[1];
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_next;
    end
  end

  // Architectural HI/LO: moves only in IDLE or on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_IDLE) begin
      if (WriteHI) r_hi <= EntradaA;
      if (WriteLO) r_lo <= EntradaA;
    end else if (r_state == ST_RUN && w_last) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit
// Randomised and directed checks of muldiv_unit against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EntradaA, EntradaB;
  logic [1:0]  OP;
  logic        Start, WriteHI, WriteLO;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .EntradaA(EntradaA), .EntradaB(EntradaB), .OP(OP),
    .Start(Start), .WriteHI(WriteHI), .WriteLO(WriteLO),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sp;
    int          sa, sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        r  = sp;
      end
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0)                                r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else                                           r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 20));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      3:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    logic [31:0] pre_hi, pre_lo;
    logic [63:0] exp;
    int          busy_cnt;
    bit          done_seen, held;
    exp = ref_result(op, a, b);
    @(negedge clk);
    pre_hi = HI;
    pre_lo = LO;
    Start = 1'b1; OP = op; EntradaA = a; EntradaB = b;
    @(negedge clk);
    Start = 1'b0; EntradaA = $urandom; EntradaB = $urandom; OP = 2'($urandom);
    busy_cnt = 0; done_seen = 1'b0; held = 1'b1;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (Done) done_seen = 1'b1;
      else begin
        if (Busy) busy_cnt++;
        if (HI !== pre_hi || LO !== pre_lo) held = 1'b0;
        Start = 1'b0; WriteHI = 1'b0;
        if (disturb && (busy_cnt == 10 || busy_cnt == 20)) begin
          Start = 1'b1; WriteHI = 1'b1; EntradaA = 32'h55;
        end
        @(negedge clk);
      end
    end
    Start = 1'b0; WriteHI = 1'b0;
    check({tag, " done"}, 64'(done_seen), 64'd1);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " hilo_held"}, 64'(held), 64'd1);
    check({tag, " HI"}, 64'(HI), 64'(exp[63:32]));
    check({tag, " LO"}, 64'(LO), 64'(exp[31:0]));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(Done), 64'd0);
    @(negedge clk);
    check({tag, " idle_after"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int cnt;
    bit stray;
    rst = 1'b1; Start = 1'b0; WriteHI = 1'b0; WriteLO = 1'b0;
    EntradaA = '0; EntradaB = '0; OP = '0;
    repeat (3) @(negedge clk);
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Done", 64'(Done), 64'd0);
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    rst = 1'b0;

    run_op("multu_small", 2'b01, 32'd2001, 32'd4001, 1'b0);
    run_op("divu_small", 2'b11, 32'd4001, 32'd2001, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("multu_big", 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_zero", 2'b11, 32'd123, 32'd0, 1'b0);
    run_op("div_zero", 2'b10, 32'hFFFF_FF85, 32'd0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("busy_ignore", 2'b01, 32'd7, 32'd9, 1'b1);

    // Direct register writes in IDLE.
    @(negedge clk);
    WriteLO = 1'b1; EntradaA = 32'hAA;
    @(negedge clk);
    WriteLO = 1'b0;
    check("mtlo LO", 64'(LO), 64'hAA);
    WriteHI = 1'b1; WriteLO = 1'b1; EntradaA = 32'h1234_5678;
    @(negedge clk);
    WriteHI = 1'b0; WriteLO = 1'b0;
    check("mthi_mtlo HI", 64'(HI), 64'h1234_5678);
    check("mthi_mtlo LO", 64'(LO), 64'h1234_5678);

    // Reset in the middle of an operation.
    Start = 1'b1; OP = 2'b00; EntradaA = 32'hDEAD_BEEF; EntradaB = 32'h0BAD_F00D;
    @(negedge clk);
    Start = 1'b0;
    cnt = 1;
    while (cnt < 15) begin
      @(negedge clk);
      cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst Busy", 64'(Busy), 64'd0);
    check("midrst Done", 64'(Done), 64'd0);
    check("midrst HI", 64'(HI), 64'd0);
    check("midrst LO", 64'(LO), 64'd0);
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy || HI != 32'd0 || LO != 32'd0) stray = 1'b1;
    end
    check("midrst quiet", 64'(stray), 64'd0);
    run_op("after_rst", 2'b11, 32'd1000, 32'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op("random", 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside `alu`.
- Consumes the same operand buses (`EntradaA`, `EntradaB`) and a 2-bit op code.
- Computes MULT/MULTU/DIV/DIVU radix-2, one bit per cycle, into architectural HI/LO registers.
- The control unit stalls the pipeline on Busy; HI/LO feed the writeback mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; iteration count = WIDTH; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- EntradaA  in  WIDTH  operand A (multiplicand / dividend); data source for WriteHI/WriteLO
- EntradaB  in  WIDTH  operand B (multiplier / divisor)
- OP  in  2  op code: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- Start  in  1  request to begin an operation; sampled only in IDLE
- WriteHI  in  1  MTHI: HI <= EntradaA; honoured only in IDLE
- WriteLO  in  1  MTLO: LO <= EntradaA; honoured only in IDLE
- Busy  out  1  high while in RUN
- Done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle
- HI  out  WIDTH  product upper half / remainder
- LO  out  WIDTH  product lower half / quotient

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0, internal operand/sign registers = 0.
- Reset mid-operation: abort immediately; same reset values; no partial result is written.
- States:
  - IDLE: if Start, latch EntradaA, EntradaB, OP and the operand signs; take absolute values for signed ops; counter=0; go to RUN.
  - RUN: one shift/add (multiply) or shift/subtract-restore (divide) step per cycle. On the step with counter==WIDTH-1, write the sign-corrected result to HI/LO and go to DONE.
  - DONE: Done=1 for this single cycle; go to IDLE unconditionally.
- Latency:
  - Start sampled at edge N; Busy=1 after edges N..N+WIDTH-1 (WIDTH cycles).
  - HI/LO update and Done=1 after edge N+WIDTH.
  - Earliest next Start is accepted at edge N+WIDTH+1.
- Start while RUN/DONE is ignored; no queueing. Operand inputs may change freely after Start is accepted.
- WriteHI/WriteLO:
  - Ignored in RUN/DONE.
  - In IDLE with Start also high, the write is applied, and the operation proceeds and later overwrites HI/LO.
  - WriteHI and WriteLO together in one cycle: both take EntradaA.
- HI/LO are stable between updates. During RUN they hold their old values; intermediate values are internal only.
- Multiply:
  - {HI,LO} = full 2*WIDTH-bit product.
  - MULT: two's-complement result, negated when the operand signs differ.
  - MULTU: unsigned result.
- Divide:
  - LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero (both DIV and DIVU): LO = all ones, HI = EntradaA as latched; full latency; Done still pulses.
- Signed overflow (DIV, A = 0x80000000, B = 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- Datapath registers:
  - Multiply: 2*WIDTH accumulator.
  - Divide: WIDTH+1-bit partial-remainder subtractor.
  - The counter is $clog2(WIDTH)+1 bits wide.

Decomposition:
- Package muldiv_pkg holds:
  - OP encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: ST_IDLE, ST_RUN, ST_DONE.
- Single module; no sub-module is needed. Datapath and FSM fit in one file of about 200 lines.

Test Plan:
- Unsigned small values:
  - MULTU A=2001, B=4001 -> after 32 Busy cycles, Done pulse; HI=0x00000000, LO=0x007A2971.
  - DIVU A=4001, B=2001 -> LO=1, HI=2000.
- Signed:
  - MULT A=0xFFFFFFFF (-1), B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
  - DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Corner cases:
  - DIVU A=123, B=0 -> LO=0xFFFFFFFF, HI=123.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Handshake:
  - Start asserted on cycles 10 and 20 of a running op -> second Start ignored; exactly one Done.
  - WriteHI=1 with A=0x55 during RUN -> HI unchanged until the result.
  - WriteLO=1 with A=0xAA in IDLE -> LO=0xAA next cycle.
- Reset:
  - rst=1 at RUN cycle 15 -> next cycle Busy=0, Done=0, HI=LO=0, state IDLE.
  - A new Start then completes normally.
